// File: rtl/riscv_pkg.sv
// Shared RISC-V control definitions: opcodes, ALU/result selects and FSM
// state encodings. Imported by control_fsm, branch_eval and the decoder.
// Optional TRAP state exists only when CONTROL_FSM_ILLEGAL_TRAP_EN is defined.
package riscv_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [1:0] {
    ADD_OP    = 2'd0,
    BRANCH_OP = 2'd1,
    ALU_OP    = 2'd2
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'd0,
    SRCA_OLDPC = 2'd1,
    SRCA_RS1   = 2'd2,
    SRCA_ZERO  = 2'd3
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2    = 2'd0,
    SRCB_IMM    = 2'd1,
    SRCB_CONST4 = 2'd2
  } alu_src_b_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'd0,
    RES_MEMDATA   = 2'd1,
    RES_ALURESULT = 2'd2
  } result_src_e;

  // State encodings kept as plain constants so legacy debug tooling can
  // decode state_o numerically.
  typedef logic [3:0] state_t;
  localparam state_t S_FETCH     = 4'd0;
  localparam state_t S_DECODE    = 4'd1;
  localparam state_t S_MEM_ADR   = 4'd2;
  localparam state_t S_MEM_READ  = 4'd3;
  localparam state_t S_MEM_WB    = 4'd4;
  localparam state_t S_MEM_WRITE = 4'd5;
  localparam state_t S_EXEC_R    = 4'd6;
  localparam state_t S_EXEC_I    = 4'd7;
  localparam state_t S_ALU_WB    = 4'd8;
  localparam state_t S_BRANCH    = 4'd9;
  localparam state_t S_JAL       = 4'd10;
  localparam state_t S_JALR_ADR  = 4'd11;
  localparam state_t S_JALR      = 4'd12;
  localparam state_t S_LUI       = 4'd13;
  localparam state_t S_AUIPC     = 4'd14;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
  localparam state_t S_TRAP      = 4'd15;
`endif

endpackage

// File: rtl/control_fsm_branch_eval.sv
// Branch condition resolution: maps func3 and comparator flags to a
// take/not-take decision. Purely combinational.
module branch_eval
  import riscv_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       br_eq,
  input  logic       br_lt,
  input  logic       br_ltu,
  output logic       take
);

  // Select the comparator flag (or its inverse) named by func3.
  always_comb begin
    take = 1'b0;
    case (func3)
      3'b000:  take = br_eq;
      3'b001:  take = ~br_eq;
      3'b100:  take = br_lt;
      3'b101:  take = ~br_lt;
      3'b110:  take = br_ltu;
      3'b111:  take = ~br_ltu;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle RISC-V main control FSM. Moore outputs per state, except
// pcWrite (FETCH, BRANCH) and irWrite (FETCH) which follow inputs.
// Define CONTROL_FSM_ILLEGAL_TRAP_EN to add the TRAP state and illegal port.
module control_fsm
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       br_eq,
  input  logic       br_lt,
  input  logic       br_ltu,
  output logic       mem_req,
  input  logic       mem_ready,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic       memWrite,
  output logic       adrSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] resultSrc,
  output logic [1:0] aluCtrl,
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
  output logic       illegal,
`endif
  output logic [3:0] state_o
);

  state_t state_q, state_d;
  logic   take;
  logic   mem_req_raw, pc_write_raw, ir_write_raw, reg_write_raw, mem_write_raw;

  branch_eval u_branch_eval (
    .func3  (func3),
    .br_eq  (br_eq),
    .br_lt  (br_lt),
    .br_ltu (br_ltu),
    .take   (take)
  );

  // State register; reset lands directly in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state selection and per-state datapath controls.
  always_comb begin
    state_d       = state_q;
    mem_req_raw   = 1'b0;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    adrSrc        = 1'b0;
    aluSrcA       = SRCA_PC;
    aluSrcB       = SRCB_RS2;
    resultSrc     = RES_ALUOUT;
    aluCtrl       = ADD_OP;
    case (state_q)
      S_FETCH: begin
        mem_req_raw  = 1'b1;
        aluSrcB      = SRCB_CONST4;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute PC-relative target into ALUOUT for branches.
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEM_ADR;
          OPC_OP:              state_d = S_EXEC_R;
          OPC_OP_IMM:          state_d = S_EXEC_I;
          OPC_BRANCH:          state_d = S_BRANCH;
          OPC_JAL:             state_d = S_JAL;
          OPC_JALR:            state_d = S_JALR_ADR;
          OPC_LUI:             state_d = S_LUI;
          OPC_AUIPC:           state_d = S_AUIPC;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
          default:             state_d = S_TRAP;
`else
          default:             state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        // opcode[5] separates STORE from LOAD.
        state_d = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req_raw = 1'b1;
        adrSrc      = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_raw = 1'b1;
        resultSrc     = RES_MEMDATA;
        state_d       = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req_raw   = 1'b1;
        mem_write_raw = 1'b1;
        adrSrc        = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_RS2;
        aluCtrl = ALU_OP;
        state_d = S_ALU_WB;
      end
      S_EXEC_I: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        aluCtrl = ALU_OP;
        state_d = S_ALU_WB;
      end
      S_LUI: begin
        aluSrcA = SRCA_ZERO;
        aluSrcB = SRCB_IMM;
        state_d = S_ALU_WB;
      end
      S_AUIPC: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA      = SRCA_RS1;
        aluSrcB      = SRCB_RS2;
        aluCtrl      = BRANCH_OP;
        pc_write_raw = take;
        state_d      = S_FETCH;
      end
      S_JALR_ADR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        state_d = S_JALR;
      end
      S_JAL, S_JALR: begin
        // Jump target already in ALUOUT; ALU forms the link value.
        aluSrcA      = SRCA_OLDPC;
        aluSrcB      = SRCB_CONST4;
        pc_write_raw = 1'b1;
        state_d      = S_ALU_WB;
      end
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are masked by reset so they drop immediately, even mid-access.
  always_comb begin
    mem_req  = rst_n & mem_req_raw;
    pcWrite  = rst_n & pc_write_raw;
    irWrite  = rst_n & ir_write_raw;
    regWrite = rst_n & reg_write_raw;
    memWrite = rst_n & mem_write_raw;
  end

  assign state_o = state_q;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
  assign illegal = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Directed testbench for control_fsm. Observed outputs are packed as
// {state, mem_req, pcWrite, irWrite, regWrite, memWrite, adrSrc,
//  aluSrcA, aluSrcB, resultSrc, aluCtrl}.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       br_eq, br_lt, br_ltu;
  logic       mem_req, mem_ready;
  logic       pcWrite, irWrite, regWrite, memWrite, adrSrc;
  logic [1:0] aluSrcA, aluSrcB, resultSrc, aluCtrl;
  logic [3:0] state_o;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int checks = 0;
  int failures = 0;

  control_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .func3     (func3),
    .br_eq     (br_eq),
    .br_lt     (br_lt),
    .br_ltu    (br_ltu),
    .mem_req   (mem_req),
    .mem_ready (mem_ready),
    .pcWrite   (pcWrite),
    .irWrite   (irWrite),
    .regWrite  (regWrite),
    .memWrite  (memWrite),
    .adrSrc    (adrSrc),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .resultSrc (resultSrc),
    .aluCtrl   (aluCtrl),
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
    .illegal   (illegal),
`endif
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {state_o, mem_req, pcWrite, irWrite, regWrite, memWrite, adrSrc,
                aluSrcA, aluSrcB, resultSrc, aluCtrl};

  function automatic logic [17:0] ev(input logic [3:0] st, input logic mr, pw, iw, rw, mw, adr,
                                     input logic [1:0] a, b, rs, ac);
    return {st, mr, pw, iw, rw, mw, adr, a, b, rs, ac};
  endfunction

  // Common expected vectors
  function automatic logic [17:0] fetch_go();   return ev(0,1,1,1,0,0,0,0,2,0,0); endfunction
  function automatic logic [17:0] fetch_idle(); return ev(0,1,0,0,0,0,0,0,2,0,0); endfunction
  function automatic logic [17:0] decode_v();   return ev(1,0,0,0,0,0,0,1,1,0,0); endfunction
  function automatic logic [17:0] aluwb_v();    return ev(8,0,0,0,1,0,0,0,0,0,0); endfunction
  function automatic logic [17:0] in_reset();   return ev(0,0,0,0,0,0,0,0,2,0,0); endfunction

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 7'd0; func3 = 3'd0;
    br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0;
    #2;
    checks++;
    if (obs !== in_reset()) begin
      failures++; $display("FAIL reset_async: got %h expected %h", obs, in_reset());
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== in_reset()) begin
      failures++; $display("FAIL reset_hold: got %h expected %h", obs, in_reset());
    end
    mem_ready = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== fetch_idle()) begin
      failures++; $display("FAIL reset_release: got %h expected %h", obs, fetch_idle());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_r_type();
    logic [17:0] e [5];
    e[0] = fetch_go(); e[1] = decode_v(); e[2] = ev(6,0,0,0,0,0,0,2,0,0,2);
    e[3] = aluwb_v();  e[4] = fetch_idle();
    opcode = 7'b0110011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i != 4);
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++; $display("FAIL r_type cyc%0d: got %h expected %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fetch_stall_opimm();
    logic [17:0] e [7];
    logic        r [7];
    e[0] = fetch_idle(); e[1] = fetch_idle(); e[2] = fetch_go(); e[3] = decode_v();
    e[4] = ev(7,0,0,0,0,0,0,2,1,0,2); e[5] = aluwb_v(); e[6] = fetch_idle();
    r = '{0,0,1,1,1,1,0};
    opcode = 7'b0010011;
    for (int i = 0; i < 7; i++) begin
      mem_ready = r[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++; $display("FAIL stall_opimm cyc%0d: got %h expected %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load();
    logic [17:0] e [9];
    logic        r [9];
    e[0] = fetch_go(); e[1] = decode_v(); e[2] = ev(2,0,0,0,0,0,0,2,1,0,0);
    for (int k = 3; k < 7; k++) e[k] = ev(3,1,0,0,0,0,1,0,0,0,0);
    e[7] = ev(4,0,0,0,1,0,0,0,0,1,0); e[8] = fetch_idle();
    r = '{1,1,1,0,0,0,1,1,0};
    opcode = 7'b0000011;
    for (int i = 0; i < 9; i++) begin
      mem_ready = r[i];
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++; $display("FAIL load cyc%0d: got %h expected %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store();
    logic [17:0] e [5];
    e[0] = fetch_go(); e[1] = decode_v(); e[2] = ev(2,0,0,0,0,0,0,2,1,0,0);
    e[3] = ev(5,1,0,0,0,1,1,0,0,0,0); e[4] = fetch_idle();
    opcode = 7'b0100011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i != 4);
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++; $display("FAIL store cyc%0d: got %h expected %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    // {func3, eq, lt, ltu, take}
    logic [6:0] tbl [8];
    logic [17:0] e [4];
    tbl = '{7'b000_100_1, 7'b000_011_0, 7'b010_111_0, 7'b001_000_1,
            7'b101_010_0, 7'b110_001_1, 7'b111_001_0, 7'b100_010_1};
    opcode = 7'b1100011;
    for (int t = 0; t < 8; t++) begin
      func3 = tbl[t][6:4]; br_eq = tbl[t][3]; br_lt = tbl[t][2]; br_ltu = tbl[t][1];
      e[0] = fetch_go(); e[1] = decode_v();
      e[2] = ev(9,0,tbl[t][0],0,0,0,0,2,0,0,1); e[3] = fetch_idle();
      for (int i = 0; i < 4; i++) begin
        mem_ready = (i != 3);
        #1;
        checks++;
        if (obs !== e[i]) begin
          failures++; $display("FAIL branch%0d cyc%0d: got %h expected %h", t, i, obs, e[i]);
        end
        @(posedge clk); #1;
      end
    end
    func3 = 3'd0; br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0;
  endtask

  task automatic test_lui_auipc();
    logic [6:0]  opc [2];
    logic [17:0] ex  [2];
    logic [17:0] e   [5];
    opc = '{7'b0110111, 7'b0010111};
    ex  = '{ev(13,0,0,0,0,0,0,3,1,0,0), ev(14,0,0,0,0,0,0,1,1,0,0)};
    for (int t = 0; t < 2; t++) begin
      opcode = opc[t];
      e[0] = fetch_go(); e[1] = decode_v(); e[2] = ex[t]; e[3] = aluwb_v(); e[4] = fetch_idle();
      for (int i = 0; i < 5; i++) begin
        mem_ready = (i != 4);
        #1;
        checks++;
        if (obs !== e[i]) begin
          failures++; $display("FAIL upper%0d cyc%0d: got %h expected %h", t, i, obs, e[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jumps();
    logic [17:0] e [6];
    // JAL
    e[0] = fetch_go(); e[1] = decode_v(); e[2] = ev(10,0,1,0,0,0,0,1,2,0,0);
    e[3] = aluwb_v(); e[4] = fetch_idle();
    opcode = 7'b1101111;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i != 4);
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++; $display("FAIL jal cyc%0d: got %h expected %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
    // JALR
    e[0] = fetch_go(); e[1] = decode_v(); e[2] = ev(11,0,0,0,0,0,0,2,1,0,0);
    e[3] = ev(12,0,1,0,0,0,0,1,2,0,0); e[4] = aluwb_v(); e[5] = fetch_idle();
    opcode = 7'b1100111;
    for (int i = 0; i < 6; i++) begin
      mem_ready = (i != 5);
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++; $display("FAIL jalr cyc%0d: got %h expected %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_write();
    logic [17:0] e [5];
    e[0] = fetch_go(); e[1] = decode_v(); e[2] = ev(2,0,0,0,0,0,0,2,1,0,0);
    e[3] = ev(5,1,0,0,0,1,1,0,0,0,0); e[4] = e[3];
    opcode = 7'b0100011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i < 2);
      #1;
      checks++;
      if (obs !== e[i]) begin
        failures++; $display("FAIL wr_rst cyc%0d: got %h expected %h", i, obs, e[i]);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
    // Now in MEM_WRITE cycle 2 with mem_ready low: drop reset mid-cycle.
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== in_reset()) begin
      failures++; $display("FAIL wr_rst_drop: got %h expected %h", obs, in_reset());
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== in_reset()) begin
      failures++; $display("FAIL wr_rst_low: got %h expected %h", obs, in_reset());
    end
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== fetch_idle()) begin
      failures++; $display("FAIL wr_rst_release: got %h expected %h", obs, fetch_idle());
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== fetch_idle()) begin
      failures++; $display("FAIL wr_rst_after: got %h expected %h", obs, fetch_idle());
    end
  endtask

  task automatic test_illegal();
    opcode = 7'b0000000;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== fetch_go()) begin
      failures++; $display("FAIL illegal_fetch: got %h expected %h", obs, fetch_go());
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== decode_v()) begin
      failures++; $display("FAIL illegal_decode: got %h expected %h", obs, decode_v());
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (obs !== ev(15,0,0,0,0,0,0,0,0,0,0) || illegal !== 1'b1) begin
        failures++;
        $display("FAIL trap cyc%0d: got %h illegal=%b expected %h illegal=1",
                 i, obs, illegal, ev(15,0,0,0,0,0,0,0,0,0,0));
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== fetch_idle() || illegal !== 1'b0) begin
      failures++; $display("FAIL trap_exit: got %h illegal=%b expected %h", obs, illegal, fetch_idle());
    end
`else
    #1;
    checks++;
    if (obs !== fetch_idle()) begin
      failures++; $display("FAIL illegal_nop: got %h expected %h", obs, fetch_idle());
    end
`endif
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_fetch_stall_opimm();
    test_load();
    test_store();
    test_branch();
    test_lui_auipc();
    test_jumps();
    test_reset_mid_write();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
